// File: rtl/fetch_queue_if.sv
// Handshake and data bundle between the fetch stage register, the fetch queue and decode.
// The master side drives fetch/decode inputs; the slave side is the queue itself.
interface fetch_queue_if #(
    parameter int LOG2_DEPTH = 2
);
    logic                  flush;
    logic                  pre_valid;
    logic                  cur_allowin;
    logic [31:0]           in_pc;
    logic [31:0]           in_inst;
    logic                  post_allowin;
    logic                  goon_valid;
    logic [31:0]           out_pc;
    logic [31:0]           out_inst;
    logic                  out_adel;
    logic [LOG2_DEPTH:0]   count;

    modport master (
        output flush, pre_valid, in_pc, in_inst, post_allowin,
        input  cur_allowin, goon_valid, out_pc, out_inst, out_adel, count
    );

    modport slave (
        input  flush, pre_valid, in_pc, in_inst, post_allowin,
        output cur_allowin, goon_valid, out_pc, out_inst, out_adel, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode with single-cycle flush.
// Optional macro FQ_ADEL_CHECK_EN tags misaligned PCs and replaces their instruction with a nop.
module fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int LOG2_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_queue_if.slave fq
);
    localparam int                  CNT_W    = LOG2_DEPTH + 1;
    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE = LOG2_DEPTH'(1);

    logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [31:0] pc_q   [DEPTH];
    logic [31:0] inst_q [DEPTH];

    logic        push, pop;
    logic [31:0] wr_inst;

`ifdef FQ_ADEL_CHECK_EN
    logic        adel_q [DEPTH];
    logic        wr_adel;

    assign wr_adel     = (fq.in_pc[1:0] != 2'b00);
    assign wr_inst     = wr_adel ? 32'h0000_0000 : fq.in_inst;
    assign fq.out_adel = adel_q[rd_ptr_q];
`else
    assign wr_inst     = fq.in_inst;
    assign fq.out_adel = 1'b0;
`endif

    // Handshake outputs come from registered state only, apart from the flush qualifier.
    assign fq.cur_allowin = (cnt_q != CNT_FULL);
    assign fq.goon_valid  = (cnt_q != '0) && !fq.flush;
    assign fq.out_pc      = pc_q[rd_ptr_q];
    assign fq.out_inst    = inst_q[rd_ptr_q];
    assign fq.count       = cnt_q;

    assign push = fq.pre_valid && fq.cur_allowin && !fq.flush;
    assign pop  = fq.goon_valid && fq.post_allowin;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (fq.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
            else if (pop && !push) cnt_d = cnt_q - CNT_ONE;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            // NOTE: storage is cleared on reset so stale head outputs read as zero afterwards.
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
`ifdef FQ_ADEL_CHECK_EN
                adel_q[i] <= 1'b0;
`endif
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            if (push) begin
                pc_q[wr_ptr_q]   <= fq.in_pc;
                inst_q[wr_ptr_q] <= wr_inst;
`ifdef FQ_ADEL_CHECK_EN
                adel_q[wr_ptr_q] <= wr_adel;
`endif
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH      = 4;
    localparam int LOG2_DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    entry_t model_q[$];

    fetch_queue_if #(.LOG2_DEPTH(LOG2_DEPTH)) fq ();

    fetch_queue #(.DEPTH(DEPTH), .LOG2_DEPTH(LOG2_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic entry_t make_entry(input logic [31:0] pc, input logic [31:0] inst);
        entry_t e;
        e.pc = pc;
`ifdef FQ_ADEL_CHECK_EN
        e.adel = (pc % 4) != 0;
        e.inst = e.adel ? 32'h0 : inst;
`else
        e.adel = 1'b0;
        e.inst = inst;
`endif
        return e;
    endfunction

    // Drive one cycle's inputs and compare the outputs against the model.
    task automatic apply(input logic fl, input logic pv, input logic pa,
                         input logic [31:0] pc, input logic [31:0] inst);
        fq.flush        = fl;
        fq.pre_valid    = pv;
        fq.post_allowin = pa;
        fq.in_pc        = pc;
        fq.in_inst      = inst;
        #1;
        check("count", 32'(fq.count), model_q.size());
        check("cur_allowin", 32'(fq.cur_allowin), 32'(model_q.size() != DEPTH));
        check("goon_valid", 32'(fq.goon_valid), 32'(model_q.size() != 0 && !fl));
        if (model_q.size() != 0) begin
            check("out_pc", fq.out_pc, model_q[0].pc);
            check("out_inst", fq.out_inst, model_q[0].inst);
            check("out_adel", 32'(fq.out_adel), 32'(model_q[0].adel));
        end
    endtask

    // Advance the model by the queue's rules, then clock the DUT.
    task automatic tick();
        if (fq.flush) begin
            model_q.delete();
        end else begin
            bit was_full = (model_q.size() == DEPTH);
            bit do_pop   = (model_q.size() != 0) && fq.post_allowin;
            if (do_pop) void'(model_q.pop_front());
            if (fq.pre_valid && !was_full) model_q.push_back(make_entry(fq.in_pc, fq.in_inst));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        fq.flush        = 1'b0;
        fq.pre_valid    = 1'b0;
        fq.post_allowin = 1'b0;
        fq.in_pc        = '0;
        fq.in_inst      = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_q.delete();
        apply(0, 0, 0, 0, 0);
        check("rst_out_pc", fq.out_pc, 32'h0);
        check("rst_out_inst", fq.out_inst, 32'h0);
        check("rst_out_adel", 32'(fq.out_adel), 32'h0);
        check("rst_allowin", 32'(fq.cur_allowin), 32'h1);
        check("rst_goon", 32'(fq.goon_valid), 32'h0);
        check("rst_count", 32'(fq.count), 32'h0);
    endtask

    initial begin
        logic [31:0] pc;

        do_reset();

        // Fill to full with decode stalled; the fifth PC must be refused.
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 0, 32'hBFC0_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
            check("fill_count", 32'(fq.count), (i < 4) ? i : 4);
            check("fill_allowin", 32'(fq.cur_allowin), (i < 4) ? 1 : 0);
            if (i > 0) check("fill_head", fq.out_pc, 32'hBFC0_0000);
            tick();
        end
        apply(0, 0, 0, 0, 0);
        check("full_count", 32'(fq.count), 4);
        check("full_allowin", 32'(fq.cur_allowin), 0);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 1, 0, 0);
            check("drain_pc", fq.out_pc, 32'hBFC0_0000 + 32'(4 * i));
            check("drain_goon", 32'(fq.goon_valid), 1);
            tick();
        end
        apply(0, 0, 1, 0, 0);
        check("drained_goon", 32'(fq.goon_valid), 0);
        check("drained_count", 32'(fq.count), 0);
        tick();

        // Hold two entries with simultaneous push and pop across pointer wrap.
        pc = 32'h0000_1000;
        for (int i = 0; i < 2; i++) begin
            apply(0, 1, 0, pc, pc ^ 32'hA5A5_0000);
            pc += 4;
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            apply(0, 1, 1, pc, pc ^ 32'hA5A5_0000);
            check("pp_count", 32'(fq.count), 2);
            check("pp_head", fq.out_pc, 32'h0000_1000 + 32'(4 * i));
            pc += 4;
            tick();
        end

        // Top up to full, then push+pop while full: only the pop happens.
        for (int i = 0; i < 2; i++) begin
            apply(0, 1, 0, pc, pc);
            pc += 4;
            tick();
        end
        apply(0, 1, 1, pc, pc);
        check("fullpop_allowin", 32'(fq.cur_allowin), 0);
        tick();
        apply(0, 0, 0, 0, 0);
        check("fullpop_count", 32'(fq.count), 3);
        check("fullpop_allowin_after", 32'(fq.cur_allowin), 1);

        // Flush with concurrent push.
        apply(1, 1, 1, 32'h8000_0000, 32'h1111_1111);
        check("flush_goon", 32'(fq.goon_valid), 0);
        tick();
        apply(0, 0, 0, 0, 0);
        check("postflush_count", 32'(fq.count), 0);
        check("postflush_goon", 32'(fq.goon_valid), 0);
        tick();
        apply(0, 1, 0, 32'h1234_0000, 32'h2222_2222);
        tick();
        apply(0, 0, 1, 0, 0);
        check("postflush_head", fq.out_pc, 32'h1234_0000);
        tick();

        // Misaligned PC.
        apply(0, 1, 0, 32'hBFC0_0002, 32'h2408_0001);
        tick();
        apply(0, 0, 0, 0, 0);
`ifdef FQ_ADEL_CHECK_EN
        check("adel_flag", 32'(fq.out_adel), 1);
        check("adel_inst", fq.out_inst, 32'h0000_0000);
`else
        check("adel_flag", 32'(fq.out_adel), 0);
        check("adel_inst", fq.out_inst, 32'h2408_0001);
`endif
        tick();
        apply(0, 0, 1, 0, 0);
        tick();

        // Random traffic, with a reset in the middle.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            apply($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 2) != 0, $urandom, $urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue between the fetch stage register and the decode stage.
- Each entry buffers one {pc, inst} pair. Fetch can keep running while decode stalls, and decode sees a registered valid.
- Uses the same valid/allowin handshake as the rest of the pipeline. A branch-redirect flush clears all entries in one cycle.

Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- LOG2_DEPTH, 2: log2(DEPTH); sets pointer width. Occupancy width is LOG2_DEPTH+1.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- flush  input  1  branch/exception redirect; empties the queue
- pre_valid  input  1  fetch stage presents a valid {in_pc, in_inst}
- cur_allowin  output  1  queue can accept a push this cycle
- in_pc  input  32  PC of the incoming instruction
- in_inst  input  32  incoming instruction word
- post_allowin  input  1  decode stage accepts the head entry this cycle
- goon_valid  output  1  head entry is valid for decode
- out_pc  output  32  PC of the head entry
- out_inst  output  32  instruction word of the head entry
- out_adel  output  1  head entry has a misaligned PC (see Optional Feature)
- count  output  LOG2_DEPTH+1  current occupancy, 0..DEPTH

Behaviour:
- Storage and pointers:
  - Circular buffer with head pointer rd_ptr and tail pointer wr_ptr, each LOG2_DEPTH bits.
  - Pointers wrap naturally: DEPTH-1 → 0.
  - Occupancy register cnt is LOG2_DEPTH+1 bits; count = cnt.
- Outputs:
  - cur_allowin = (cnt != DEPTH). It depends only on registered state; there is no combinational path from post_allowin.
  - goon_valid = (cnt != 0) && !flush.
  - out_pc, out_inst and out_adel are the contents of entry rd_ptr. When cnt==0 they hold stale contents; consumers must qualify them with goon_valid.
- Push/pop:
  - push = pre_valid && cur_allowin && !flush. On push, writes {in_pc, in_inst} to entry wr_ptr and increments wr_ptr.
  - pop = goon_valid && post_allowin. On pop, increments rd_ptr.
- Counter update:
  - push only: cnt+1. Pop only: cnt-1. Both or neither: cnt unchanged.
  - Push and pop in the same cycle are legal at any occupancy except full. When full, no push occurs, so only the pop happens.
  - When cnt==0 in the same cycle as a push, pop is 0 (goon_valid=0). The new entry is visible the next cycle, so minimum latency is 1 cycle.
- Full: cur_allowin=0. pre_valid is ignored and the fetch stage must hold its data. A pop while full frees a slot, and cur_allowin rises the next cycle.
- Empty: goon_valid=0, and post_allowin has no effect.
- Flush:
  - Next cycle: rd_ptr=0, wr_ptr=0, cnt=0.
  - In the flush cycle, push and pop are both suppressed and goon_valid=0.
  - Flush has priority over every other event. Back-to-back flushes are legal.
- Reset:
  - rd_ptr=0, wr_ptr=0, cnt=0. All entry storage (pc, inst, adel) is cleared to 0.
  - Reset-time outputs: cur_allowin=1, goon_valid=0, out_pc=0, out_inst=0, out_adel=0, count=0.
  - Reset mid-operation discards all entries, exactly like flush plus clearing the storage.

Optional Feature:
- Macro: FQ_ADEL_CHECK_EN.
- Defined:
  - Each entry stores an adel bit = (in_pc[1:0] != 2'b00), captured at push.
  - If adel=1, the entry's inst field is stored as 32'h0000_0000 (nop) instead of in_inst.
  - out_adel reflects the head entry's adel bit.
- Not defined: no adel storage, out_adel is tied to 0, and in_inst is stored unmodified.

Test Plan:
- Fill and full:
  - Stimulus: reset, then pre_valid=1 with in_pc=0xBFC00000, 0xBFC00004, ... and post_allowin=0 for 5 cycles.
  - Required: count goes 1, 2, 3, 4; cur_allowin=0 after the 4th push. The 5th PC (0xBFC00010) is not accepted. out_pc=0xBFC00000 throughout.
- Drain order:
  - Stimulus: from full, pre_valid=0 and post_allowin=1 for 4 cycles.
  - Required: out_pc sequence 0xBFC00000, 04, 08, 0C; goon_valid=0 and count=0 on the 5th cycle.
- Simultaneous push/pop with wrap:
  - Stimulus: hold cnt=2 with pre_valid=1 and post_allowin=1 for 10 cycles.
  - Required: count stays 2 and pointers wrap past 3→0. Output PCs remain strictly sequential in steps of +4 with no duplicates or drops.
- Full with pop:
  - Stimulus: cnt=4, pre_valid=1, post_allowin=1 for one cycle.
  - Required: pop only, no push; count=3 next cycle and cur_allowin=1.
- Flush with concurrent push:
  - Stimulus: cnt=3, then flush=1 together with pre_valid=1 (in_pc=0x80000000).
  - Required: goon_valid=0 in that cycle; next cycle count=0 and goon_valid=0. 0x80000000 is not enqueued.
- Misaligned PC (FQ_ADEL_CHECK_EN defined):
  - Stimulus: push in_pc=0xBFC00002 with in_inst=0x24080001.
  - Required: out_adel=1 and out_inst=0x00000000. With the macro undefined: out_adel=0 and out_inst=0x24080001.
